// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//
// Producer end of the fetch->decode interface. Keeps the program counter,
// issues reads to a synchronous instruction memory and buffers the returned
// 16-bit words, each tagged with its PC, in a small prefetch FIFO. The decoder
// consumes words from the FIFO head over a valid/ready handshake. A redirect
// flushes the FIFO and restarts fetching at a new address. Words that were
// already in flight when the redirect happened are dropped when they return.
//
// Ports
//   CLOCK_50      in   1       sole clock, rising edge
//   reset         in   1       asynchronous, active-high, clears all state
//   imem_req      out  1       memory read request (registered)
//   imem_addr     out  ADDR_W  memory read address (registered)
//   imem_rdata    in   16      read data, valid the cycle after memory samples req
//   fetchoutput   out  16      instruction word at the FIFO head
//   fetch_pc      out  ADDR_W  PC of fetchoutput
//   fetch_valid   out  1       FIFO head is valid
//   decode_ready  in   1       decoder accepts; transfer = fetch_valid & decode_ready
//   redirect      in   1       one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc   in   ADDR_W  restart address
//   halt          in   1       level; no new requests while high
//
// Optional build macro
//   FETCH_SLOW_CLOCK_EN : a divider counting 0..DIV_MAX gates new requests to one
//   every DIV_MAX+1 cycles. Pushes, the handshake and redirect keep the full rate.

module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DIV_MAX  = 217
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       fetchoutput,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_valid,
  input  logic              decode_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              epoch;
  logic [CW-1:0]     count;
  logic [CW-1:0]     pending;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [15:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  // Tracks the request the memory sampled at the last edge, so its data
  // (valid during this cycle) can be pushed at the coming edge.
  logic              resp_valid;
  logic              resp_epoch;
  logic [ADDR_W-1:0] resp_addr;

  logic              tick;
  logic [CW:0]       occupancy;
  logic              room;
  logic              issue;
  logic              push;
  logic              pop;

`ifdef FETCH_SLOW_CLOCK_EN
  localparam int DW = $clog2(DIV_MAX + 1);
  logic [DW-1:0] div_count;

  // Free-running divider; a request may only be issued when it reaches DIV_MAX.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_count <= '0;
    end else if (div_count == DW'(DIV_MAX)) begin
      div_count <= '0;
    end else begin
      div_count <= div_count + DW'(1);
    end
  end

  assign tick = (div_count == DW'(DIV_MAX));
`else
  logic div_unused;
  assign div_unused = (DIV_MAX == 0);
  assign tick       = 1'b1;
`endif

  // Space is reserved for every request still in flight, so the FIFO can
  // never overflow when those responses land.
  assign occupancy = {1'b0, count} + {1'b0, pending};
  assign room      = (occupancy < (CW + 1)'(DEPTH));

  // The edge that leaves IDLE already issues the first request; this is what
  // lets the first word be valid after the third edge following reset.
  assign issue = ((state == RUN) || (state == IDLE)) && !halt && !redirect
                 && room && tick;

  // Responses from before the last redirect carry the old epoch and are dropped.
  assign push = resp_valid && (resp_epoch == epoch);
  assign pop  = fetch_valid && decode_ready;

  assign fetch_valid = (count != '0);
  assign fetchoutput = fifo_data[head];
  assign fetch_pc    = fifo_pc[head];

  // Main sequential block: control state, PC, request port, response
  // tracking and FIFO storage. Redirect overrides the FIFO update, which
  // voids any transfer happening in the same cycle.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      epoch      <= 1'b0;
      count      <= '0;
      pending    <= '0;
      head       <= '0;
      tail       <= '0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      resp_valid <= 1'b0;
      resp_epoch <= 1'b0;
      resp_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else begin
      resp_valid <= imem_req;
      resp_addr  <= imem_addr;
      resp_epoch <= epoch;

      pending  <= pending + CW'(issue) - CW'(resp_valid);
      imem_req <= issue;
      if (issue) begin
        imem_addr <= pc;
        pc        <= pc + ADDR_W'(1);
      end

      if (redirect) begin
        state <= RUN;
        pc    <= redirect_pc;
        epoch <= ~epoch;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        case (state)
          IDLE:    state <= RUN;
          RUN:     state <= halt ? HALTED : RUN;
          HALTED:  state <= halt ? HALTED : RUN;
          default: state <= IDLE;
        endcase

        if (push) begin
          fifo_data[tail] <= imem_rdata;
          fifo_pc[tail]   <= resp_addr;
          tail            <= tail + PW'(1);
        end
        if (pop) begin
          head <= head + PW'(1);
        end

        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit
//
// Self-checking bench for instruction_fetch_unit with default parameters.
// A behavioural synchronous memory answers requests. The bench queues the PC
// sequence it expects the decoder to see, and a monitor pops and compares it
// on every transfer. The slow-clock build is exercised when
// FETCH_SLOW_CLOCK_EN is defined.

module tb_instruction_fetch_unit;

  logic        CLOCK_50;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] fetchoutput;
  logic [15:0] fetch_pc;
  logic        fetch_valid;
  logic        decode_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;

  int          checks;
  int          errors;
  int          xfer_count;
  int          cyc;
  logic [15:0] exp_q[$];

  instruction_fetch_unit dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .fetchoutput  (fetchoutput),
    .fetch_pc     (fetch_pc),
    .fetch_valid  (fetch_valid),
    .decode_ready (decode_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt)
  );

  // 50 MHz clock.
  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Memory contents: the four known words at 0..3, a scrambled address elsewhere.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'd0:   mem_word = 16'h1001;
      16'd1:   mem_word = 16'h2002;
      16'd2:   mem_word = 16'h3003;
      16'd3:   mem_word = 16'h4004;
      default: mem_word = a ^ 16'hA55A;
    endcase
  endfunction

  // Synchronous instruction memory: samples req at the edge, data next cycle.
  initial imem_rdata = 16'h0;
  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", tag, actual, expected, $time);
    end
  endtask

  task automatic push_expected(input logic [15:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 16'(i));
  endtask

  // Moves to the sampling point after the next active edge.
  task automatic next_sample();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  // Moves to just after the next active edge, where inputs are driven.
  task automatic apply_stimulus();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_req"},   imem_req,    0);
    check_output({tag, "_addr"},  imem_addr,   0);
    check_output({tag, "_valid"}, fetch_valid, 0);
    check_output({tag, "_word"},  fetchoutput, 0);
    check_output({tag, "_pc"},    fetch_pc,    0);
  endtask

  task automatic check_throughput(input string tag, input int n);
    int start;
    #1;
    start = xfer_count;
    repeat (n) @(negedge CLOCK_50);
    #1;
    check_output(tag, xfer_count - start, n);
  endtask

  // Scoreboard monitor: a transfer happens at the coming edge unless a
  // redirect voids it.
  always @(negedge CLOCK_50) begin
    logic [15:0] pc_e;
    if (!reset && fetch_valid && decode_ready && !redirect) begin
      xfer_count++;
      if (exp_q.size() == 0) begin
        check_output("sb_empty", 1, 0);
      end else begin
        pc_e = exp_q.pop_front();
        check_output("sb_pc", fetch_pc, pc_e);
        check_output("sb_word", fetchoutput, mem_word(pc_e));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

`ifdef FETCH_SLOW_CLOCK_EN
  // Waits for the next cycle with imem_req high, bounded in cycles.
  task automatic wait_req(input string tag, output int at);
    int n;
    n = 0;
    at = 0;
    @(negedge CLOCK_50);
    while (imem_req !== 1'b1 && n < 600) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 600) check_output(tag, 0, 1);
    at = cyc;
  endtask
`endif

  initial begin
    checks       = 0;
    errors       = 0;
    xfer_count   = 0;
    cyc          = 0;
    reset        = 1'b1;
    decode_ready = 1'b1;
    redirect     = 1'b0;
    redirect_pc  = 16'h0;
    halt         = 1'b0;

    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_values("rst");

    push_expected(16'h0000, 400);
    reset = 1'b0;

`ifdef FETCH_SLOW_CLOCK_EN
    begin
      int t0;
      int t1;
      wait_req("slow_first_req", t0);
      check_output("slow_first_addr", imem_addr, 16'h0000);
      wait_req("slow_second_req", t1);
      check_output("slow_gap1", t1 - t0, 218);
      t0 = t1;
      wait_req("slow_third_req", t1);
      check_output("slow_gap2", t1 - t0, 218);
      check_output("slow_third_addr", imem_addr, 16'h0002);
    end
`else
    // First request at the edge leaving IDLE, first word after the third edge.
    next_sample();
    check_output("lat_req1", imem_req, 1);
    check_output("lat_addr1", imem_addr, 16'h0000);
    check_output("lat_valid1", fetch_valid, 0);
    next_sample();
    check_output("lat_valid2", fetch_valid, 0);
    next_sample();
    check_output("lat_valid3", fetch_valid, 1);
    check_throughput("tput_run", 10);

    // Decoder stalls: the FIFO fills to DEPTH and requests stop.
    apply_stimulus();
    decode_ready = 1'b0;
    repeat (20) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    begin
      logic [15:0] h;
      h = exp_q[0];
      check_output("stall_req", imem_req, 0);
      check_output("stall_valid", fetch_valid, 1);
      check_output("stall_head", fetch_pc, h);
      check_output("stall_last_addr", imem_addr, h + 16'd3);
    end
    apply_stimulus();
    decode_ready = 1'b1;
    check_throughput("tput_drain", 8);

    // Redirect while two requests are in flight.
    apply_stimulus();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    push_expected(16'h0040, 200);
    apply_stimulus();
    redirect = 1'b0;
    @(negedge CLOCK_50);
    check_output("redir_valid0", fetch_valid, 0);
    next_sample();
    check_output("redir_req", imem_req, 1);
    check_output("redir_addr", imem_addr, 16'h0040);
    check_output("redir_valid1", fetch_valid, 0);
    repeat (10) @(negedge CLOCK_50);

    // Address wrap from FFFF to 0000.
    apply_stimulus();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    push_expected(16'hFFFE, 200);
    apply_stimulus();
    redirect = 1'b0;
    repeat (12) @(negedge CLOCK_50);

    // Halt: in-flight words complete and drain, no new requests.
    apply_stimulus();
    halt = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_output("halt_req", imem_req, 0);
    check_output("halt_valid", fetch_valid, 0);
    apply_stimulus();
    halt = 1'b0;
    repeat (10) @(negedge CLOCK_50);

    // Reset mid-stream with requests pending.
    apply_stimulus();
    reset = 1'b1;
    #1;
    check_reset_values("midrst");
    push_expected(16'h0000, 200);
    #1;
    reset = 1'b0;
    next_sample();
    check_output("midrst_valid1", fetch_valid, 0);
    next_sample();
    check_output("midrst_valid2", fetch_valid, 0);
    next_sample();
    check_output("midrst_valid3", fetch_valid, 1);
    check_output("midrst_first_pc", fetch_pc, 16'h0000);
    repeat (8) @(negedge CLOCK_50);
`endif

    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
